// File: rtl/score_table_arbiter.sv
// ----------------------------------------------------------------------------
// score_table_arbiter
//
// Shares one single-port score BRAM between NUM_PE random-walk engines and
// sequences the walk steps. Each RUN cycle at most one requesting engine is
// granted. Every other engine sees conflict=1 and holds its request. Read
// data comes back one cycle after the grant, tagged by a one-hot rvalid. Once
// every engine has reported finished for the current level, a one-cycle SYNC
// state pulses finished_all and advances l_step. After MAX_STEPS levels the
// block parks in DONE until reset.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             leave IDLE and begin a run
//   i_req_valid/_we     per-engine request and write enable
//   i_req_addr/_wdata   per-engine address / write data, packed by engine
//   i_finished          per-engine "level complete" flag
//   o_conflict          1 = engine not served this cycle
//   o_rvalid, o_rdata   one-hot read return and broadcast read data
//   o_rdy               engines may run (RUN only)
//   o_l_step            current step index
//   o_finished_all      one-cycle pulse at step end
//   o_done              all steps complete
//   o_bram_*, i_bram_rdata  single-port BRAM, 1-cycle synchronous read
//
// Build option
//   SCORE_ARB_FIXED_PRIO_EN : lowest requesting index always wins and the
//   round-robin pointer is removed (tied to 0). Default is round-robin.
// ----------------------------------------------------------------------------
module score_table_arbiter #(
    parameter int NUM_PE     = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STEPS  = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [NUM_PE-1:0]            i_req_valid,
    input  logic [NUM_PE-1:0]            i_req_we,
    input  logic [NUM_PE*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_PE*DATA_WIDTH-1:0] i_req_wdata,
    input  logic [NUM_PE-1:0]            i_finished,
    output logic [NUM_PE-1:0]            o_conflict,
    output logic [NUM_PE-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]        o_rdata,
    output logic                         o_rdy,
    output logic [DATA_WIDTH-1:0]        o_l_step,
    output logic                         o_finished_all,
    output logic                         o_done,
    output logic [ADDR_WIDTH-1:0]        o_bram_addr,
    output logic                         o_bram_we,
    output logic [DATA_WIDTH-1:0]        o_bram_wdata,
    input  logic [DATA_WIDTH-1:0]        i_bram_rdata
);

    localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SYNC,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PTR_W-1:0]      w_rr_ptr;
    logic                  w_grant_any;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [NUM_PE-1:0]     w_read_grant;
    logic [NUM_PE-1:0]     r_fin_seen;
    logic [DATA_WIDTH-1:0] r_l_step;
    logic [DATA_WIDTH-1:0] w_l_step_inc;
    logic [NUM_PE-1:0]     r_rvalid;

`ifdef SCORE_ARB_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_rr_ptr_next;

    assign w_rr_ptr_next = (w_grant_idx == PTR_W'(NUM_PE - 1)) ? '0 : w_grant_idx + 1'b1;

    // The pointer only moves on an actual grant, so idle cycles keep fairness.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_RUN && w_grant_any) begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    // Two-pass search: first requester at or above the pointer, otherwise
    // wrap around and take the lowest requester.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (!w_grant_any && i_req_valid[i] && (PTR_W'(i) >= w_rr_ptr)) begin
                w_grant_any = 1'b1;
                w_grant_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_PE; i++) begin
            if (!w_grant_any && i_req_valid[i]) begin
                w_grant_any = 1'b1;
                w_grant_idx = PTR_W'(i);
            end
        end
    end

    // BRAM port mux and conflict vector. Outside RUN every engine is stalled
    // and the BRAM is left idle.
    always_comb begin
        o_conflict   = '1;
        o_bram_addr  = '0;
        o_bram_we    = 1'b0;
        o_bram_wdata = '0;
        w_read_grant = '0;
        if (r_state == ST_RUN) begin
            o_conflict = '0;
            for (int i = 0; i < NUM_PE; i++) begin
                if (w_grant_any && (w_grant_idx == PTR_W'(i))) begin
                    o_conflict      = '1;
                    o_conflict[i]   = 1'b0;
                    o_bram_addr     = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    o_bram_we       = i_req_we[i];
                    o_bram_wdata    = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    w_read_grant[i] = ~i_req_we[i];
                end
            end
        end
    end

    assign w_l_step_inc = r_l_step + DATA_WIDTH'(1);

    // A granted access always wins over the step change. SYNC is only entered
    // on an idle cycle, so nothing is in flight across the level boundary.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_RUN;
            ST_RUN:  if ((&r_fin_seen) && !w_grant_any) w_state_next = ST_SYNC;
            ST_SYNC: w_state_next = (w_l_step_inc == DATA_WIDTH'(MAX_STEPS)) ? ST_DONE : ST_RUN;
            ST_DONE: w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, sticky finish flags, step counter and the read-return tag.
    // Reset drops a read in flight by clearing r_rvalid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_fin_seen <= '0;
            r_l_step   <= '0;
            r_rvalid   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= w_read_grant;
            if (r_state == ST_RUN) begin
                r_fin_seen <= r_fin_seen | i_finished;
            end else if (r_state == ST_SYNC) begin
                r_fin_seen <= '0;
                r_l_step   <= w_l_step_inc;
            end
        end
    end

    assign o_rvalid       = r_rvalid;
    assign o_rdata        = (|r_rvalid) ? i_bram_rdata : '0;
    assign o_rdy          = (r_state == ST_RUN);
    assign o_finished_all = (r_state == ST_SYNC);
    assign o_done         = (r_state == ST_DONE);
    assign o_l_step       = r_l_step;

endmodule

// File: tb/tb_score_table_arbiter.sv
// ----------------------------------------------------------------------------
// tb_score_table_arbiter
//
// Directed bench for score_table_arbiter with NUM_PE=4. A behavioural BRAM
// with a 1-cycle synchronous read sits on the BRAM port. A shadow copy of its
// contents supplies expected read data. Each granted read pushes
// {engine, data} onto a queue, and the entry is popped and compared on the
// following cycle.
// ----------------------------------------------------------------------------
module tb_score_table_arbiter;

    localparam int NPE = 4;
    localparam int AW  = 13;
    localparam int DW  = 32;

    typedef struct {
        int          eng;
        logic [31:0] data;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [NPE-1:0]      reqValid;
    logic [NPE-1:0]      reqWe;
    logic [NPE*AW-1:0]   reqAddr;
    logic [NPE*DW-1:0]   reqWdata;
    logic [NPE-1:0]      finished;
    logic [NPE-1:0]      conflict;
    logic [NPE-1:0]      rvalid;
    logic [DW-1:0]       rdata;
    logic                rdy;
    logic [DW-1:0]       lStep;
    logic                finishedAll;
    logic                done;
    logic [AW-1:0]       bramAddr;
    logic                bramWe;
    logic [DW-1:0]       bramWdata;
    logic [DW-1:0]       bramRdata;

    logic [DW-1:0]       bramMem   [0:(1<<AW)-1];
    logic [DW-1:0]       shadowMem [0:(1<<AW)-1];
    exp_t                expQ[$];
    int                  checks;
    int                  failures;
    int                  pulseCount;

    score_table_arbiter #(
        .NUM_PE    (NPE),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_STEPS (7)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_req_valid   (reqValid),
        .i_req_we      (reqWe),
        .i_req_addr    (reqAddr),
        .i_req_wdata   (reqWdata),
        .i_finished    (finished),
        .o_conflict    (conflict),
        .o_rvalid      (rvalid),
        .o_rdata       (rdata),
        .o_rdy         (rdy),
        .o_l_step      (lStep),
        .o_finished_all(finishedAll),
        .o_done        (done),
        .o_bram_addr   (bramAddr),
        .o_bram_we     (bramWe),
        .o_bram_wdata  (bramWdata),
        .i_bram_rdata  (bramRdata)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(int a);
        return (32'(a) * 32'h0000_9E37) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural single-port BRAM, read-first, 1-cycle read latency
    initial begin
        for (int a = 0; a < (1 << AW); a++) bramMem[a] = initWord(a);
    end
    always @(posedge clk) begin
        if (bramWe) bramMem[bramAddr] <= bramWdata;
        bramRdata <= bramMem[bramAddr];
    end

    // Counts finished_all pulses seen at clock edges
    initial pulseCount = 0;
    always @(posedge clk) begin
        if (finishedAll === 1'b1) pulseCount = pulseCount + 1;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearReq;
        reqValid = '0;
        reqWe    = '0;
        reqAddr  = '0;
        reqWdata = '0;
    endtask

    task automatic setReq(input int eng, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        reqValid[eng]           = 1'b1;
        reqWe[eng]              = we;
        reqAddr[eng*AW +: AW]   = addr;
        reqWdata[eng*DW +: DW]  = data;
    endtask

    task automatic applyStimulus(input logic [NPE-1:0] fin, input logic st);
        finished = fin;
        start    = st;
        #1;
    endtask

    // Checks that engine eng is the grantee and records the expected effect
    task automatic checkGrant(input string tag, input int eng, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [NPE-1:0] expC;
        exp_t           e;
        expC = ~(NPE'(1) << eng);
        checkOutput({tag, "_conflict"}, 64'(conflict), 64'(expC));
        checkOutput({tag, "_addr"}, 64'(bramAddr), 64'(addr));
        checkOutput({tag, "_we"}, 64'(bramWe), 64'(we));
        if (we) begin
            checkOutput({tag, "_wdata"}, 64'(bramWdata), 64'(data));
            shadowMem[addr] = data;
        end else begin
            e.eng  = eng;
            e.data = shadowMem[addr];
            expQ.push_back(e);
        end
    endtask

    // Compares the read return for the grant made in the previous cycle
    task automatic checkReturn(input string tag);
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'(NPE'(1) << e.eng));
            checkOutput({tag, "_rdata"}, 64'(rdata), 64'(e.data));
        end else begin
            checkOutput({tag, "_rvalid_idle"}, 64'(rvalid), 64'(0));
        end
    endtask

    initial begin
        int g;
        int n;
        checks   = 0;
        failures = 0;
        for (int a = 0; a < (1 << AW); a++) shadowMem[a] = initWord(a);

        // Reset state
        rst = 1'b1;
        clearReq();
        applyStimulus('0, 1'b0);
        tick();
        tick();
        checkOutput("rst_rdy", 64'(rdy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_fin_all", 64'(finishedAll), 64'(0));
        checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
        checkOutput("rst_rdata", 64'(rdata), 64'(0));
        checkOutput("rst_conflict", 64'(conflict), 64'(4'hF));
        checkOutput("rst_bram_we", 64'(bramWe), 64'(0));
        checkOutput("rst_bram_addr", 64'(bramAddr), 64'(0));
        checkOutput("rst_bram_wdata", 64'(bramWdata), 64'(0));
        checkOutput("rst_l_step", 64'(lStep), 64'(0));

        // Start: RUN next cycle, idle bus
        rst = 1'b0;
        applyStimulus('0, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("start_rdy", 64'(rdy), 64'(1));
        checkOutput("start_l_step", 64'(lStep), 64'(0));
        checkOutput("start_conflict", 64'(conflict), 64'(0));
        checkOutput("start_bram_we", 64'(bramWe), 64'(0));

        // Engines 0 and 2 read together; 0 wins, then 2
        setReq(0, 1'b0, 13'h010, '0);
        setReq(2, 1'b0, 13'h020, '0);
        #1;
        checkGrant("rd_e0", 0, 1'b0, 13'h010, '0);
        tick();
        checkReturn("ret_e0");
        clearReq();
        setReq(2, 1'b0, 13'h020, '0);
        #1;
        checkGrant("rd_e2", 2, 1'b0, 13'h020, '0);
        tick();
        checkReturn("ret_e2");

        // Engine 3 alone at the top address; pointer wraps to 0 afterwards
        clearReq();
        setReq(3, 1'b0, 13'h1FFF, '0);
        #1;
        checkGrant("rd_e3", 3, 1'b0, 13'h1FFF, '0);
        tick();
        checkReturn("ret_e3");

        // All four engines request continuously
        for (int c = 0; c < 5; c++) begin
            clearReq();
            for (int i = 0; i < NPE; i++) setReq(i, 1'b0, AW'(13'h100 + i), '0);
            #1;
`ifdef SCORE_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = c % NPE;
`endif
            checkGrant($sformatf("rot%0d", c), g, 1'b0, AW'(13'h100 + g), '0);
            tick();
            checkReturn($sformatf("rot_ret%0d", c));
        end

        // Engine 1 writes 5 to address 12, then reads it back
        clearReq();
        setReq(1, 1'b1, 13'd12, 32'h0000_0005);
        #1;
        checkGrant("wr_e1", 1, 1'b1, 13'd12, 32'h0000_0005);
        tick();
        checkReturn("wr_ret");
        clearReq();
        setReq(1, 1'b0, 13'd12, '0);
        #1;
        checkGrant("rd_e1", 1, 1'b0, 13'd12, '0);
        tick();
        checkReturn("raw_ret");

        // Step 1: finished flags arrive on different cycles, the last one
        // together with a granted read; start in RUN must be ignored
        clearReq();
        applyStimulus(4'b0001, 1'b0);
        checkOutput("fin0_fin_all", 64'(finishedAll), 64'(0));
        tick();
        applyStimulus(4'b0010, 1'b1);
        tick();
        applyStimulus(4'b0100, 1'b0);
        tick();
        setReq(2, 1'b0, 13'h030, '0);
        applyStimulus(4'b1000, 1'b0);
        checkGrant("fin_grant", 2, 1'b0, 13'h030, '0);
        checkOutput("fin_grant_fin_all", 64'(finishedAll), 64'(0));
        tick();
        checkReturn("fin_ret");
        clearReq();
        applyStimulus('0, 1'b0);
        checkOutput("fin_idle_rdy", 64'(rdy), 64'(1));
        checkOutput("fin_idle_fin_all", 64'(finishedAll), 64'(0));
        tick();
        checkReturn("sync_ret");
        setReq(0, 1'b1, 13'h040, 32'hDEAD_BEEF);
        #1;
        checkOutput("sync_fin_all", 64'(finishedAll), 64'(1));
        checkOutput("sync_rdy", 64'(rdy), 64'(0));
        checkOutput("sync_conflict", 64'(conflict), 64'(4'hF));
        checkOutput("sync_l_step", 64'(lStep), 64'(0));
        checkOutput("sync_bram_we", 64'(bramWe), 64'(0));
        tick();
        clearReq();
        #1;
        checkReturn("post_sync_ret");
        checkOutput("step1_rdy", 64'(rdy), 64'(1));
        checkOutput("step1_l_step", 64'(lStep), 64'(1));
        checkOutput("step1_fin_all", 64'(finishedAll), 64'(0));
        checkOutput("step1_pulses", 64'(pulseCount), 64'(1));
        tick();
        tick();
        tick();
        checkOutput("step1_hold_pulses", 64'(pulseCount), 64'(1));
        checkOutput("step1_hold_rdy", 64'(rdy), 64'(1));

        // Steps 2..7 with all engines finishing at once
        for (int s = 2; s <= 7; s++) begin
            applyStimulus(4'hF, 1'b0);
            tick();
            applyStimulus('0, 1'b0);
            n = 0;
            while (finishedAll !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checkOutput($sformatf("step%0d_sync_seen", s), 64'(n < 10), 64'(1));
            checkOutput($sformatf("step%0d_sync_l_step", s), 64'(lStep), 64'(s - 1));
            tick();
            if (s < 7) begin
                checkOutput($sformatf("step%0d_rdy", s), 64'(rdy), 64'(1));
                checkOutput($sformatf("step%0d_l_step", s), 64'(lStep), 64'(s));
            end
        end
        checkOutput("done_done", 64'(done), 64'(1));
        checkOutput("done_rdy", 64'(rdy), 64'(0));
        checkOutput("done_l_step", 64'(lStep), 64'(7));
        checkOutput("done_conflict", 64'(conflict), 64'(4'hF));
        checkOutput("done_pulses", 64'(pulseCount), 64'(7));
        applyStimulus('0, 1'b1);
        tick();
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("done_hold", 64'(done), 64'(1));
        checkOutput("done_hold_pulses", 64'(pulseCount), 64'(7));

        // Reset while a granted read is in flight
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus('0, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        setReq(0, 1'b0, 13'h055, '0);
        #1;
        checkGrant("mid_rd", 0, 1'b0, 13'h055, '0);
        rst = 1'b1;
        tick();
        expQ.delete();
        checkOutput("mid_rvalid", 64'(rvalid), 64'(0));
        checkOutput("mid_rdata", 64'(rdata), 64'(0));
        checkOutput("mid_rdy", 64'(rdy), 64'(0));
        checkOutput("mid_conflict", 64'(conflict), 64'(4'hF));
        checkOutput("mid_bram_we", 64'(bramWe), 64'(0));
        checkOutput("mid_bram_addr", 64'(bramAddr), 64'(0));
        checkOutput("mid_l_step", 64'(lStep), 64'(0));
        checkOutput("mid_done", 64'(done), 64'(0));
        rst = 1'b0;
        tick();
        checkOutput("mid_idle_rdy", 64'(rdy), 64'(0));
        checkOutput("mid_idle_rvalid", 64'(rvalid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_table_arbiter.md
# score_table_arbiter

Shared-port arbiter and step controller for the score-table BRAM. It is the responder side of the engine-to-score-table protocol: up to NUM_PE diffusion random-walk engines issue read/write requests to one single-port score BRAM, and the arbiter grants one per cycle, stalls the losers through `conflict`, and returns read data. It also owns the walk-step sequencing: it drives `rdy`, `l_step` and the one-cycle `finished_all` pulse from the engines' `finished` flags.

## Interface
Parameters:
- NUM_PE, 4: number of engines; must be ≥ 2.
- ADDR_WIDTH, 13: score BRAM address width.
- DATA_WIDTH, 32: score word width; also the width of `l_step`.
- MAX_STEPS, 7: number of walk steps before `done`.

Ports:
- clk  in  1: single clock; all state changes on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: begins a run from IDLE; ignored in any other state.
- req_valid  in  NUM_PE: engine i requests a BRAM access this cycle.
- req_we  in  NUM_PE: 1 = write, 0 = read, per engine.
- req_addr  in  NUM_PE*ADDR_WIDTH: engine i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PE*DATA_WIDTH: write data, same slicing.
- finished  in  NUM_PE: engine i has completed its node range for the current step (level).
- conflict  out  NUM_PE: 1 = engine i is not served this cycle and must hold its request.
- rvalid  out  NUM_PE: one-hot; `rdata` belongs to engine i.
- rdata  out  DATA_WIDTH: read data broadcast to all engines.
- rdy  out  1: engines may run.
- l_step  out  DATA_WIDTH: current step index.
- finished_all  out  1: one-cycle pulse at step end.
- done  out  1: all MAX_STEPS steps complete.
- bram_addr  out  ADDR_WIDTH, bram_we  out  1, bram_wdata  out  DATA_WIDTH, bram_rdata  in  DATA_WIDTH: single-port BRAM with 1-cycle synchronous read.

## Operation
- States: IDLE, RUN, SYNC, DONE.
- IDLE → RUN on `start`. `rdy` is 1 only in RUN.
- RUN, arbitration (combinational):
  - Among engines with `req_valid`=1, grant the first index ≥ `rr_ptr`, wrapping around.
  - Grantee gets `conflict`=0. Every other engine gets `conflict`=1, whether or not it is requesting.
  - If no engine requests, all `conflict` bits are 0 and `bram_we`=0.
  - `bram_addr`, `bram_we` and `bram_wdata` are taken from the grantee's slices.
  - On the rising edge, `rr_ptr` ← (grantee+1) mod NUM_PE. It is unchanged when there is no grant.
- Read return:
  - A granted read at cycle t produces `rvalid`[grantee]=1 and `rdata`=`bram_rdata` at cycle t+1.
  - Writes produce no `rvalid`.
- Finish tracking:
  - `fin_seen`[i] is sticky; it sets while `finished`[i]=1.
  - RUN → SYNC when all `fin_seen` bits are 1 and no request is granted this cycle.
- SYNC (1 cycle):
  - `finished_all`=1 and `rdy`=0; all `conflict` bits are 1.
  - `fin_seen` is cleared and `l_step` increments.
  - Next state is DONE if the new `l_step` == MAX_STEPS, else RUN.
- DONE: `done`=1, `rdy`=0, all `conflict` bits 1. Held until `rst`.
- Outside RUN, `bram_we`=0 and requests are ignored.
- `l_step` wraps naturally at 2^DATA_WIDTH. This is unreachable for legal MAX_STEPS < 2^DATA_WIDTH.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `l_step`=0, `fin_seen`=0.
  - `rdy`=0, `finished_all`=0, `done`=0, `rvalid`=0, `rdata`=0.
  - `conflict`=all 1, `bram_we`=0, `bram_addr`=0, `bram_wdata`=0.
- Reset mid-operation: at the next edge, everything returns to reset values. A read that was in flight returns no `rvalid`.
- Grant-to-BRAM latency 0 (combinational). Read latency 1 cycle.
- Throughput: one access per cycle.
- Fairness: a continuously requesting engine waits at most NUM_PE-1 cycles.
- Simultaneous events:
  - The last `finished` bit may arrive in the same cycle as a grant. That access completes, and SYNC is entered on a later idle cycle.
  - `start` asserted while in RUN has no effect.
- Write-then-read of the same address on consecutive grants returns the new data. This is guaranteed by the BRAM read-after-write order, because the accesses are serialized.

## Configuration
- `SCORE_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `rr_ptr` is removed and held at 0.
- Not defined (default): round-robin as described above.

## Test plan
- Reset, then `start`: `rdy`=1 on the next cycle, `l_step`=0, all `conflict`=0 with no requests.
- Engines 0 and 2 both read with `rr_ptr`=0: engine 0 granted and `conflict`=4'b1110; next cycle engine 2 granted, `rvalid`=4'b0001, `rdata`=BRAM[addr0].
- All 4 engines request continuously: grants rotate 0,1,2,3,0; each engine waits ≤ 3 cycles. With `SCORE_ARB_FIXED_PRIO_EN`, engine 0 wins every cycle.
- Engine 1 writes 0x00000005 to addr 12, then reads addr 12: `rvalid`=4'b0010, `rdata`=0x00000005.
- `finished` asserted by all 4 engines at different cycles: exactly one `finished_all` pulse, `l_step` 0→1, `fin_seen` cleared, back in RUN. After 7 such steps, `done`=1 and `rdy`=0.
- Assert `rst` one cycle after a granted read: no `rvalid`, all outputs at reset values, state IDLE.
